// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: paces spawns off the game-time pulse, draws lane patterns from an
// LFSR, queues them in a small FIFO and presents the head entry over a valid/ready handshake.
module obstacle_scheduler #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned INIT_INTERVAL = 8,
  parameter int unsigned MIN_INTERVAL  = 3,
  parameter int unsigned RAMP_EVERY    = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        playing,
  input  logic        reset_game,
  input  logic        pulse,
  input  logic        spawn_ready,
  output logic        spawn_valid,
  output logic [2:0]  spawn_lanes,
  output logic        spawn_jumpable,
  output logic [7:0]  interval,
  output logic [11:0] spawn_count,
  output logic        overflow
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned RampMsk  = RAMP_EVERY - 1;
  localparam logic [AW:0]   FillFull = DEPTH[AW:0];
  localparam logic [AW:0]   FillOne  = 1;
  localparam logic [AW-1:0] PtrOne   = 1;
  localparam logic [7:0]    InitIv   = INIT_INTERVAL[7:0];
  localparam logic [7:0]    MinIv    = MIN_INTERVAL[7:0];
  localparam logic [11:0]   RampMask = RampMsk[11:0];

  typedef enum logic [1:0] {StIdle, StRun, StGen} state_e;

  state_e        state_q, state_d;
  logic [7:0]    countdown_q, countdown_d;
  logic [7:0]    interval_q, interval_d;
  logic [11:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [3:0]    mem_q [DEPTH];

  logic          fifo_empty, fifo_full;
  logic          gen, push, pop;
  logic [2:0]    gen_lanes;
  logic [3:0]    gen_entry, head;
  logic [11:0]   count_inc;

  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == FillFull);
  assign head       = mem_q[rd_ptr_q];

  assign spawn_valid    = !fifo_empty && playing;
  assign spawn_lanes    = fifo_empty ? 3'b000 : head[3:1];
  assign spawn_jumpable = fifo_empty ? 1'b0 : head[0];
  assign interval       = interval_q;
  assign spawn_count    = count_q;
  assign overflow       = overflow_q;

  // All-free and all-blocked patterns are remapped so every obstacle is passable yet present.
  always_comb begin
    gen_lanes = lfsr_q[2:0];
    if (lfsr_q[2:0] == 3'b000) begin
      gen_lanes = 3'b010;
    end else if (lfsr_q[2:0] == 3'b111) begin
      gen_lanes = 3'b101;
    end
  end

  assign gen_entry = {gen_lanes, lfsr_q[4]};
  assign pop       = spawn_valid && spawn_ready && !reset_game;
  assign gen       = (state_q == StGen) && !reset_game;
  assign push      = gen && (!fifo_full || pop);
  assign count_inc = (count_q == 12'hFFF) ? count_q : count_q + 12'd1;

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    interval_d  = interval_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    if (reset_game) begin
      state_d    = StIdle;
      interval_d = InitIv;
      count_d    = '0;
      overflow_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (playing) begin
            countdown_d = interval_q;
            state_d     = StRun;
          end
        end
        StRun: begin
          if (!playing) begin
            state_d = StIdle;
          end else if (pulse) begin
            if (countdown_q == 8'd1) begin
              countdown_d = interval_q;
              state_d     = StGen;
            end else begin
              countdown_d = countdown_q - 8'd1;
            end
          end
        end
        StGen: begin
          state_d = StRun;
        end
        default: state_d = StIdle;
      endcase

      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
        count_d  = count_inc;
        if (((count_inc & RampMask) == 12'd0) && (interval_q > MinIv)) begin
          interval_d = interval_q - 8'd1;
        end
      end else if (gen) begin
        overflow_d = 1'b1;
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end

      unique case ({push, pop})
        2'b10:   fill_d = fill_q + FillOne;
        2'b01:   fill_d = fill_q - FillOne;
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      countdown_q <= '0;
      interval_q  <= InitIv;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      interval_q  <= interval_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      lfsr_q      <= lfsr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= gen_entry;
    end
  end

endmodule
